// File: rtl/spi_master_axis_ingress.sv
// SPI master reader: drives csn/sclk, samples 1 or 2 MISO lanes per falling
// edge and assembles bytes into a single-register AXI-Stream output.
// SCLK is paused low between bytes while that output register is still occupied.
module spi_master_axis_ingress #(
    parameter int MSB_FIRST = 1,
    parameter int MISO_SIZE = 1,
    parameter int CLK_DIV   = 4,
    parameter int CSN_SETUP = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          byte_count,
    output logic                 busy,
    output logic                 done,
    output logic                 spi_csn,
    output logic                 spi_clk,
    input  logic [MISO_SIZE-1:0] spi_miso,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);

    localparam int          BITS       = 8 / MISO_SIZE;
    localparam logic [2:0]  BIT_LAST   = 3'(BITS - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(CSN_SETUP - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_HIGH   = 3'd2;
    localparam logic [2:0] S_LOW    = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;       // system clocks spent in the current phase
    logic [2:0]  bit_q, bit_d;       // samples taken in the current byte
    logic [15:0] bytes_q, bytes_d;   // bytes still to be clocked in
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  shift_nxt;
    logic        csn_q, csn_d;
    logic        sclk_q, sclk_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        out_free;

    assign busy          = busy_q;
    assign done          = done_q;
    assign spi_csn       = csn_q;
    assign spi_clk       = sclk_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

    // Output register can take a new byte at the next edge.
    assign out_free = !tvalid_q || m_axis_tready;

    // Shift register with the current MISO sample folded in.
    always_comb begin
        if (MSB_FIRST != 0) shift_nxt = {shift_q[7-MISO_SIZE:0], spi_miso};
        else                shift_nxt = {spi_miso, shift_q[7:MISO_SIZE]};
    end

    // Next-state logic for the sequencer and the output register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        bytes_d  = bytes_q;
        shift_d  = shift_q;
        csn_d    = csn_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;

        if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (byte_count != 16'd0) begin
                        bytes_d = byte_count;
                        csn_d   = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = 16'd0;
                        bit_d   = 3'd0;
                        state_d = S_SETUP;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = 16'd0;
                    sclk_d  = 1'b1;
                    state_d = S_HIGH;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            S_HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = 16'd0;
                    sclk_d  = 1'b0;
                    shift_d = shift_nxt;
                    state_d = S_LOW;
                    if (bit_q == BIT_LAST) begin
                        // Byte gating guarantees the output register is empty here.
                        bit_d    = 3'd0;
                        tdata_d  = shift_nxt;
                        tvalid_d = 1'b1;
                        tlast_d  = (bytes_q == 16'd1);
                        bytes_d  = bytes_q - 16'd1;
                    end else begin
                        bit_d    = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 16'd0;
                    if (bit_q != 3'd0) begin
                        sclk_d  = 1'b1;
                        state_d = S_HIGH;
                    end else if (bytes_q != 16'd0) begin
                        if (out_free) begin
                            sclk_d  = 1'b1;
                            state_d = S_HIGH;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        state_d = S_FINISH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                if (out_free) begin
                    sclk_d  = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_FINISH: begin
                // Release csn first, then wait for the last byte to drain.
                if (!csn_q) begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_d = 16'd0;
                        csn_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else if (out_free) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops the link and discards any partial byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            bytes_q  <= 16'd0;
            shift_q  <= 8'd0;
            csn_q    <= 1'b1;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tdata_q  <= 8'd0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            bytes_q  <= bytes_d;
            shift_q  <= shift_d;
            csn_q    <= csn_d;
            sclk_q   <= sclk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

endmodule
